// File: rtl/ice_cream_dispense_ctrl.sv
// rtl/ice_cream_dispense_ctrl.sv - coin credit, serve sequencing and dispenser handshake controller
module ice_cream_dispense_ctrl #(
    parameter int PRICE     = 2,
    parameter int MAX_BALLS = 3,
    parameter int TIMEOUT   = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       insert,
    input  logic [1:0] coins,
    input  logic       serve,
    input  logic       disp_ack,
    input  logic       disp_done,
    output logic       disp_req,
    output logic [2:0] credit,
    output logic [1:0] balls_left,
    output logic       refund_valid,
    output logic [2:0] refund_amt,
    output logic       fault,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_REQ     = 3'd2,
        S_WAIT    = 3'd3,
        S_CHANGE  = 3'd4,
        S_FAULT   = 3'd5
    } state_t;

    localparam int         TW       = $clog2(TIMEOUT + 1);
    localparam logic [3:0] CAP      = 4'(PRICE * MAX_BALLS);
    localparam logic [3:0] PRICE4   = 4'(PRICE);
    localparam logic [3:0] MAXB4    = 4'(MAX_BALLS);
    localparam logic [TW-1:0] TMO   = TW'(TIMEOUT);

    state_t        st, st_n;
    logic          insert_prev;
    logic [TW-1:0] tmo_cnt, tmo_cnt_n, tmo_inc;
    logic [2:0]    credit_n, credit_c;
    logic [1:0]    balls_n, n_balls;
    logic          req_n, rv_n, fault_n;
    logic [2:0]    ra_n;
    logic          coin_ev;
    logic [3:0]    coin_sum, quot, cost, fault_sum;
    logic [2:0]    credit_sat, sat_refund;
    logic          sat_ovf;

    assign state = st;

    // Coin detection, saturation and the ball count a serve would buy
    always_comb begin
        coin_ev    = insert && !insert_prev && (coins != 2'b11);
        coin_sum   = {1'b0, credit} + {2'b00, coins};
        sat_ovf    = coin_sum > CAP;
        credit_sat = sat_ovf ? CAP[2:0] : coin_sum[2:0];
        sat_refund = sat_ovf ? 3'(coin_sum - CAP) : 3'd0;
        credit_c   = coin_ev ? credit_sat : credit;
        quot       = {1'b0, credit_c} / PRICE4;
        n_balls    = (quot > MAXB4) ? MAXB4[1:0] : quot[1:0];
        cost       = {2'b00, n_balls} * PRICE4;
        fault_sum  = {1'b0, credit} + ({2'b00, balls_left} * PRICE4);
        tmo_inc    = tmo_cnt + 1'b1;
    end

    // Next-state and next-output logic
    always_comb begin
        st_n      = st;
        credit_n  = credit;
        balls_n   = balls_left;
        tmo_cnt_n = tmo_cnt;
        rv_n      = 1'b0;
        ra_n      = 3'd0;
        fault_n   = fault;
        case (st)
            S_IDLE: begin
                if (coin_ev && coins != 2'b00) begin
                    credit_n = credit_sat;
                    rv_n     = sat_ovf;
                    ra_n     = sat_refund;
                    st_n     = S_COLLECT;
                end
            end
            S_COLLECT: begin
                credit_n = credit_c;
                rv_n     = coin_ev && sat_ovf;
                ra_n     = coin_ev ? sat_refund : 3'd0;
                if (serve && n_balls != 2'd0) begin
                    balls_n  = n_balls;
                    credit_n = credit_c - cost[2:0];
                    st_n     = S_REQ;
                end
            end
            S_REQ: begin
                if (disp_ack) begin
                    tmo_cnt_n = '0;
                    st_n      = S_WAIT;
                end
            end
            S_WAIT: begin
                tmo_cnt_n = tmo_inc;
                if (disp_done) begin
                    balls_n = balls_left - 2'd1;
                    if (balls_left > 2'd1) begin
                        st_n = S_REQ;
                    end else begin
                        st_n     = S_CHANGE;
                        rv_n     = 1'b1;
                        ra_n     = credit;
                        credit_n = 3'd0;
                    end
                end else if (tmo_inc == TMO) begin
                    st_n     = S_FAULT;
                    rv_n     = 1'b1;
                    ra_n     = fault_sum[2:0];
                    credit_n = 3'd0;
                    balls_n  = 2'd0;
                    fault_n  = 1'b1;
                end
            end
            S_CHANGE: st_n = S_IDLE;
            S_FAULT:  fault_n = 1'b1;
            default:  st_n = S_IDLE;
        endcase
        req_n = (st_n == S_REQ);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st           <= S_IDLE;
            credit       <= 3'd0;
            balls_left   <= 2'd0;
            disp_req     <= 1'b0;
            refund_valid <= 1'b0;
            refund_amt   <= 3'd0;
            fault        <= 1'b0;
            insert_prev  <= 1'b0;
            tmo_cnt      <= '0;
        end else begin
            st           <= st_n;
            credit       <= credit_n;
            balls_left   <= balls_n;
            disp_req     <= req_n;
            refund_valid <= rv_n;
            refund_amt   <= ra_n;
            fault        <= fault_n;
            insert_prev  <= insert;
            tmo_cnt      <= tmo_cnt_n;
        end
    end

endmodule

// File: tb/tb_ice_cream_dispense_ctrl.sv
// tb/tb_ice_cream_dispense_ctrl.sv - directed self-checking bench for ice_cream_dispense_ctrl
module tb_ice_cream_dispense_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       insert;
    logic [1:0] coins;
    logic       serve;
    logic       disp_ack;
    logic       disp_done;
    logic       disp_req;
    logic [2:0] credit;
    logic [1:0] balls_left;
    logic       refund_valid;
    logic [2:0] refund_amt;
    logic       fault;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    ice_cream_dispense_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .insert       (insert),
        .coins        (coins),
        .serve        (serve),
        .disp_ack     (disp_ack),
        .disp_done    (disp_done),
        .disp_req     (disp_req),
        .credit       (credit),
        .balls_left   (balls_left),
        .refund_valid (refund_valid),
        .refund_amt   (refund_amt),
        .fault        (fault),
        .state        (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic coin(input logic [1:0] v);
        insert = 1'b0;
        step();
        insert = 1'b1;
        coins  = v;
        step();
        insert = 1'b0;
    endtask

    task automatic handshake();
        disp_ack = 1'b1;
        step();
        disp_ack  = 1'b0;
        disp_done = 1'b1;
        step();
        disp_done = 1'b0;
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b0;
        #3;
        reset = 1'b1;
        step();
    endtask

    initial begin
        reset = 1'b0; insert = 1'b0; coins = 2'b00; serve = 1'b0;
        disp_ack = 1'b0; disp_done = 1'b0;
        steps(3);
        chk("rst_state", 8'(state), 8'd0);
        chk("rst_credit", 8'(credit), 8'd0);
        chk("rst_req", 8'(disp_req), 8'd0);
        chk("rst_fault", 8'(fault), 8'd0);
        chk("rst_rv", 8'(refund_valid), 8'd0);
        reset = 1'b1;
        step();

        // coin 2 then coin 1, serve one ball, change of 1
        coin(2'b10);
        chk("t2_credit2", 8'(credit), 8'd2);
        chk("t2_collect", 8'(state), 8'd1);
        coin(2'b01);
        chk("t2_credit3", 8'(credit), 8'd3);
        serve = 1'b1;
        step();
        serve = 1'b0;
        chk("t2_balls", 8'(balls_left), 8'd1);
        chk("t2_credit1", 8'(credit), 8'd1);
        chk("t2_req_state", 8'(state), 8'd2);
        chk("t2_req", 8'(disp_req), 8'd1);
        step();
        chk("t2_req_held", 8'(disp_req), 8'd1);
        disp_ack = 1'b1;
        step();
        disp_ack = 1'b0;
        chk("t2_wait", 8'(state), 8'd3);
        chk("t2_req_drop", 8'(disp_req), 8'd0);
        step();
        disp_done = 1'b1;
        step();
        disp_done = 1'b0;
        chk("t2_change", 8'(state), 8'd4);
        chk("t2_rv", 8'(refund_valid), 8'd1);
        chk("t2_ramt", 8'(refund_amt), 8'd1);
        chk("t2_credit0", 8'(credit), 8'd0);
        step();
        chk("t2_idle", 8'(state), 8'd0);
        chk("t2_rv_off", 8'(refund_valid), 8'd0);

        // saturation on the fourth 2-coin, then three balls
        coin(2'b10);
        coin(2'b10);
        coin(2'b10);
        chk("t3_credit6", 8'(credit), 8'd6);
        chk("t3_no_rv", 8'(refund_valid), 8'd0);
        coin(2'b10);
        chk("t3_sat_credit", 8'(credit), 8'd6);
        chk("t3_sat_rv", 8'(refund_valid), 8'd1);
        chk("t3_sat_amt", 8'(refund_amt), 8'd2);
        serve = 1'b1;
        step();
        serve = 1'b0;
        chk("t3_balls3", 8'(balls_left), 8'd3);
        chk("t3_credit0", 8'(credit), 8'd0);
        handshake();
        chk("t3_balls2", 8'(balls_left), 8'd2);
        chk("t3_back_req", 8'(state), 8'd2);
        chk("t3_req_again", 8'(disp_req), 8'd1);
        handshake();
        chk("t3_balls1", 8'(balls_left), 8'd1);
        handshake();
        chk("t3_change", 8'(state), 8'd4);
        chk("t3_rv", 8'(refund_valid), 8'd1);
        chk("t3_ramt0", 8'(refund_amt), 8'd0);
        step();
        chk("t3_idle", 8'(state), 8'd0);

        // insufficient credit, invalid coin, held insert
        coin(2'b01);
        chk("t4_credit1", 8'(credit), 8'd1);
        serve = 1'b1;
        step();
        serve = 1'b0;
        chk("t4_serve_ign", 8'(state), 8'd1);
        chk("t4_serve_cred", 8'(credit), 8'd1);
        coin(2'b11);
        chk("t4_inval_cred", 8'(credit), 8'd1);
        chk("t4_inval_state", 8'(state), 8'd1);
        insert = 1'b0;
        step();
        insert = 1'b1;
        coins  = 2'b01;
        steps(5);
        insert = 1'b0;
        chk("t4_held_once", 8'(credit), 8'd2);

        // async reset while waiting on the dispenser
        serve = 1'b1;
        step();
        serve = 1'b0;
        disp_ack = 1'b1;
        step();
        disp_ack = 1'b0;
        chk("t1_in_wait", 8'(state), 8'd3);
        #2;
        reset = 1'b0;
        #1;
        chk("t1_state", 8'(state), 8'd0);
        chk("t1_balls", 8'(balls_left), 8'd0);
        chk("t1_credit", 8'(credit), 8'd0);
        chk("t1_req", 8'(disp_req), 8'd0);
        chk("t1_rv", 8'(refund_valid), 8'd0);
        chk("t1_ramt", 8'(refund_amt), 8'd0);
        chk("t1_fault", 8'(fault), 8'd0);
        #1;
        reset = 1'b1;
        step();

        // timeout on the second ball
        coin(2'b10);
        coin(2'b10);
        coin(2'b10);
        serve = 1'b1;
        step();
        serve = 1'b0;
        handshake();
        chk("t5_balls2", 8'(balls_left), 8'd2);
        disp_ack = 1'b1;
        step();
        disp_ack = 1'b0;
        steps(14);
        chk("t5_still_wait", 8'(state), 8'd3);
        chk("t5_no_fault", 8'(fault), 8'd0);
        step();
        chk("t5_fault_state", 8'(state), 8'd5);
        chk("t5_fault", 8'(fault), 8'd1);
        chk("t5_rv", 8'(refund_valid), 8'd1);
        chk("t5_ramt4", 8'(refund_amt), 8'd4);
        chk("t5_balls0", 8'(balls_left), 8'd0);
        chk("t5_req0", 8'(disp_req), 8'd0);
        step();
        chk("t5_rv_once", 8'(refund_valid), 8'd0);
        coin(2'b10);
        serve = 1'b1;
        step();
        serve = 1'b0;
        chk("t5_coin_ign", 8'(credit), 8'd0);
        chk("t5_stuck", 8'(state), 8'd5);
        chk("t5_sticky", 8'(fault), 8'd1);
        do_reset();
        chk("t5_cleared", 8'(fault), 8'd0);

        // done on the final allowed wait cycle
        coin(2'b10);
        serve = 1'b1;
        step();
        serve = 1'b0;
        disp_ack = 1'b1;
        step();
        disp_ack = 1'b0;
        steps(14);
        disp_done = 1'b1;
        step();
        disp_done = 1'b0;
        chk("t6_late_done", 8'(state), 8'd4);
        chk("t6_late_nofault", 8'(fault), 8'd0);
        step();
        chk("t6_idle", 8'(state), 8'd0);

        // coin and serve in the same cycle
        coin(2'b01);
        chk("t6_credit1", 8'(credit), 8'd1);
        insert = 1'b0;
        step();
        insert = 1'b1;
        coins  = 2'b01;
        serve  = 1'b1;
        step();
        insert = 1'b0;
        serve  = 1'b0;
        chk("t6_same_balls", 8'(balls_left), 8'd1);
        chk("t6_same_credit", 8'(credit), 8'd0);
        chk("t6_same_state", 8'(state), 8'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ice_cream_dispense_ctrl.md
Name: ice_cream_dispense_ctrl

Overview:
- Sequencing controller between the coin-accepting front end and the physical ball dispenser of the ice-cream vending machine.
- Accumulates coin credit from insert pulses and converts it to a ball count when the customer presses serve.
- Drives the dispenser one ball at a time over a req/ack/done handshake, with a timeout watchdog.
- Returns leftover credit as change.

Parameters:
- PRICE, 2: credit units per ball.
- MAX_BALLS, 3: max balls per serve; also sets credit cap = PRICE*MAX_BALLS.
- TIMEOUT, 15: max cycles to wait for disp_done after ack before fault.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- insert  in  1  coin-present strobe; rising edge = one coin event.
- coins  in  2  coin value, sampled on the insert rising edge: 00=0, 01=1, 10=2, 11=invalid.
- serve  in  1  customer serve request, level; acted on only in COLLECT.
- disp_ack  in  1  dispenser accepted the request.
- disp_done  in  1  dispenser finished one ball (1-cycle pulse).
- disp_req  out  1  request one ball.
- credit  out  3  current credit.
- balls_left  out  2  balls still to dispense in this serve.
- refund_valid  out  1  1-cycle pulse; refund_amt is valid.
- refund_amt  out  3  change/overflow returned.
- fault  out  1  sticky dispenser-timeout flag.
- state  out  3  FSM state encoding, for debug and bench.

Behaviour:
- Reset (reset=0, async): state=IDLE, credit=0, balls_left=0, disp_req=0, refund_valid=0, refund_amt=0, fault=0, insert_prev=0, timeout counter=0.
- Coin event: insert=1 and insert_prev=0 (insert_prev registered each cycle).
  - Credit updates on the clock edge that samples the event (1-cycle latency to the credit output).
  - coins=11 ignored; coins=00 counts as an event with no credit change.
- Coin events are accepted only in IDLE and COLLECT. In other states they are dropped with no refund.
- Saturation: new = credit + value. If new > cap (6 at defaults):
  - credit = cap;
  - refund_valid=1 and refund_amt = new - cap in that same cycle.
- State encodings: IDLE=0, COLLECT=1, REQ=2, WAIT=3, CHANGE=4, FAULT=5.
- IDLE -> COLLECT on the first coin event with value > 0.
- COLLECT:
  - On serve=1, compute n = min(credit/PRICE, MAX_BALLS) (integer division).
  - If n=0, serve is ignored and the state stays COLLECT.
  - Otherwise balls_left=n, credit -= n*PRICE, next state REQ.
  - A coin event in the same cycle as serve is applied first; n uses the updated credit.
- REQ:
  - disp_req=1, held until disp_ack=1.
  - On ack: disp_req=0 next cycle, timeout counter cleared, next state WAIT.
  - No timeout applies in REQ.
- WAIT:
  - Counter increments each cycle.
  - On disp_done: balls_left -= 1; next state REQ if balls_left was >1, else CHANGE.
  - If the counter reaches TIMEOUT without disp_done: next state FAULT.
  - disp_done arriving on the TIMEOUT cycle counts as success.
- CHANGE:
  - One cycle. refund_valid=1, refund_amt=credit, credit=0.
  - Next state IDLE.
  - Credit 0 still pulses refund_valid with amt=0.
- FAULT:
  - fault=1 and disp_req=0.
  - Refund once on entry: refund_amt = credit + balls_left*PRICE; then credit=0, balls_left=0.
  - Stays in FAULT until reset. Coins and serve are ignored.
- disp_ack or disp_done outside REQ/WAIT: ignored.
- Only one refund source per cycle. The saturation refund cannot coincide with CHANGE/FAULT because coins are dropped in those states.
- All outputs registered. Arithmetic is unsigned, with widths sized so n*PRICE and the refund sum do not overflow 3 bits at defaults.

Test Plan:
- Reset mid-dispense: async reset low while in WAIT -> all outputs 0 immediately, state=0, with no clock required.
- Coin 10, coin 01, serve=1 -> credit 2, then 3; balls_left=1, credit=1; one req/ack/done cycle; CHANGE with refund_amt=1; state IDLE.
- Four coin events of 10 -> credit saturates at 6 on the 4th; refund_valid with refund_amt=2 that cycle; serve -> balls_left=3, three handshakes, refund_amt=0.
- Credit 1, serve=1 -> ignored, state stays COLLECT. Coin 11 -> credit unchanged, no state change. insert held high 5 cycles -> exactly one coin event.
- Credit 6, serve, first ball ok, second ack then no done for 15 cycles -> FAULT, fault=1, refund_amt=4 (two balls), stuck until reset; later coins ignored.
- disp_done on exactly the 15th WAIT cycle -> treated as success, no fault. Serve and coin 01 in the same COLLECT cycle with credit 1 -> n=1.
